// File: rtl/moore_seq_pkg.sv
// ============================================================================
// moore_seq_pkg : shared helpers for moore_seq_detector (state width, KMP
//                 next-state evaluation, legal pattern-length range)
// Revision      : 1.0
// ============================================================================
`default_nettype none

package moore_seq_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    function automatic int state_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Longest suffix of (first k pattern bits, b) that is also a pattern
    // prefix, capped below the full length when k == pat_w (proper suffix).
    function automatic int seq_next(input logic [PAT_W_MAX-1:0] pat,
                                    input int pat_w, input int k, input logic b);
        int   len;
        int   j;
        logic ok;
        logic c;
        len = (k + 1 < pat_w) ? k + 1 : pat_w;
        for (int l = len; l > 0; l--) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                j = k + 1 - l + i;
                c = (j == k) ? b : pat[pat_w-1-j];
                if (c != pat[pat_w-1-i]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                return l;
            end
        end
        return 0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/moore_seq_detector_next_table.sv
// ============================================================================
// seq_next_table : combinational next-state lookup (k, b) -> k', table built
//                  at elaboration from the pattern and match-state mode
// Revision       : 1.0
// ============================================================================
`default_nettype none

module seq_next_table
    import moore_seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               LOCK    = 1'b0,
    parameter int               SW      = 3
) (
    input  logic [SW-1:0] state_i,
    input  logic          bit_i,
    output logic [SW-1:0] next_o
);

    localparam logic [PAT_W_MAX-1:0] PAT_EXT = PAT_W_MAX'(PATTERN);

    logic [SW-1:0] w_nxt0 [0:PAT_W];
    logic [SW-1:0] w_nxt1 [0:PAT_W];

    for (genvar k = 0; k <= PAT_W; k++) begin : g_row
        if (k == PAT_W && LOCK) begin : g_lock
            assign w_nxt0[k] = SW'(PAT_W);
            assign w_nxt1[k] = SW'(PAT_W);
        end else if (k == PAT_W && !OVERLAP) begin : g_restart
            localparam int N0 = seq_next(PAT_EXT, PAT_W, 0, 1'b0);
            localparam int N1 = seq_next(PAT_EXT, PAT_W, 0, 1'b1);
            assign w_nxt0[k] = SW'(N0);
            assign w_nxt1[k] = SW'(N1);
        end else begin : g_kmp
            localparam int N0 = seq_next(PAT_EXT, PAT_W, k, 1'b0);
            localparam int N1 = seq_next(PAT_EXT, PAT_W, k, 1'b1);
            assign w_nxt0[k] = SW'(N0);
            assign w_nxt1[k] = SW'(N1);
        end
    end

    // Encodings above PAT_W fall through to the S0 default.
    always_comb begin
        next_o = '0;
        for (int k = 0; k <= PAT_W; k++) begin
            if (state_i == SW'(k)) begin
                next_o = bit_i ? w_nxt1[k] : w_nxt0[k];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/moore_seq_detector.sv
// ============================================================================
// moore_seq_detector : Moore serial pattern detector with optional saturating
//                      match counter (enabled by MOORE_SEQ_CNT_EN)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module moore_seq_detector
    import moore_seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               LOCK    = 1'b0,
    parameter int               CNT_W   = 8,
    localparam int              SW      = state_w(PAT_W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          din,
    input  logic          clr,
    output logic [SW-1:0] state_o,
    output logic          match
`ifdef MOORE_SEQ_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX || CNT_W < 1) begin : g_bad_param
        $error("moore_seq_detector: PAT_W or CNT_W out of range");
    end

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic [SW-1:0] w_step;

    seq_next_table #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP),
        .LOCK    (LOCK),
        .SW      (SW)
    ) u_next (
        .state_i (state_q),
        .bit_i   (din),
        .next_o  (w_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = '0;
        end else if (en) begin
            state_d = w_step;
        end
    end

    always_comb begin
        match   = (state_q == SW'(PAT_W));
        state_o = state_q;
    end

`ifdef MOORE_SEQ_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_enter;

    // Remaining in an absorbing lock state is not a fresh entry.
    assign w_enter = !clr && en && (state_d == SW'(PAT_W)) && !(LOCK && match);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (w_enter && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_moore_seq_detector.sv
// ============================================================================
// tb_moore_seq_detector : scoreboard bench driving four detector configurations
//                         (overlap, non-overlap, lock, 2-bit saturating) in step
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_moore_seq_detector;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic din;
    logic clr;

    always #5 clk = ~clk;

    logic [2:0] st_a, st_b, st_c;
    logic [1:0] st_d;
    logic       m_a, m_b, m_c, m_d;
`ifdef MOORE_SEQ_CNT_EN
    logic [7:0] c_a, c_b, c_c;
    logic [1:0] c_d;
`endif

    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .LOCK(1'b0), .CNT_W(8)) u_ovl (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr(clr), .state_o(st_a), .match(m_a)
`ifdef MOORE_SEQ_CNT_EN
        , .match_cnt(c_a)
`endif
    );

    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .LOCK(1'b0), .CNT_W(8)) u_novl (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr(clr), .state_o(st_b), .match(m_b)
`ifdef MOORE_SEQ_CNT_EN
        , .match_cnt(c_b)
`endif
    );

    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .LOCK(1'b1), .CNT_W(8)) u_lock (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr(clr), .state_o(st_c), .match(m_c)
`ifdef MOORE_SEQ_CNT_EN
        , .match_cnt(c_c)
`endif
    );

    moore_seq_detector #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .LOCK(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr(clr), .state_o(st_d), .match(m_d)
`ifdef MOORE_SEQ_CNT_EN
        , .match_cnt(c_d)
`endif
    );

    logic [4:0] act_st  [N];
    logic       act_m   [N];
    logic [7:0] act_cnt [N];

    always_comb begin
        act_st[0] = {2'b00, st_a};
        act_st[1] = {2'b00, st_b};
        act_st[2] = {2'b00, st_c};
        act_st[3] = {3'b000, st_d};
        act_m[0]  = m_a;
        act_m[1]  = m_b;
        act_m[2]  = m_c;
        act_m[3]  = m_d;
`ifdef MOORE_SEQ_CNT_EN
        act_cnt[0] = c_a;
        act_cnt[1] = c_b;
        act_cnt[2] = c_c;
        act_cnt[3] = {6'd0, c_d};
`else
        act_cnt[0] = 8'd0;
        act_cnt[1] = 8'd0;
        act_cnt[2] = 8'd0;
        act_cnt[3] = 8'd0;
`endif
    end

    int          pw   [N] = '{4, 4, 4, 2};
    logic [15:0] pat  [N] = '{16'h000B, 16'h000B, 16'h000B, 16'h0003};
    bit          ovl  [N] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit          lck  [N] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int          cmax [N] = '{255, 255, 255, 3};

    int          m_st   [N];
    int          m_hlen [N];
    int          m_cnt  [N];
    logic [31:0] m_hist [N];

    typedef struct packed {
        logic [19:0] st;
        logic [3:0]  m;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Detector state = longest suffix of the bit history that is a pattern prefix.
    function automatic int longest(input logic [31:0] h, input int hl,
                                   input logic [15:0] p, input int w);
        int lmax;
        bit ok;
        lmax = (hl < w) ? hl : w;
        for (int l = lmax; l > 0; l--) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++) begin
                if (h[l-1-j] !== p[w-1-j]) ok = 1'b0;
            end
            if (ok) return l;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i]   = 0;
            m_hlen[i] = 0;
            m_cnt[i]  = 0;
            m_hist[i] = '0;
        end
    endtask

    task automatic model_step(input bit e, input bit d, input bit c);
        int prev;
        for (int i = 0; i < N; i++) begin
            if (c) begin
                m_st[i]   = 0;
                m_hlen[i] = 0;
                m_cnt[i]  = 0;
            end else if (e) begin
                prev = m_st[i];
                if (!(lck[i] && prev == pw[i])) begin
                    if (!ovl[i] && prev == pw[i]) m_hlen[i] = 0;
                    m_hist[i] = {m_hist[i][30:0], d};
                    if (m_hlen[i] < 32) m_hlen[i]++;
                    m_st[i] = longest(m_hist[i], m_hlen[i], pat[i], pw[i]);
                end
                if (m_st[i] == pw[i] && !(lck[i] && prev == pw[i]) && m_cnt[i] < cmax[i])
                    m_cnt[i]++;
            end
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            e.st[i*5 +: 5]  = 5'(m_st[i]);
            e.m[i]          = (m_st[i] == pw[i]);
            e.cnt[i*8 +: 8] = 8'(m_cnt[i]);
        end
        return e;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            for (int i = 0; i < N; i++) begin
                checks++;
                assert (act_st[i] === e.st[i*5 +: 5]) else begin
                    errors++;
                    $error("FAIL %s state_o[dut%0d] observed=%0d expected=%0d", tag, i, act_st[i], e.st[i*5 +: 5]);
                end
                checks++;
                assert (act_m[i] === e.m[i]) else begin
                    errors++;
                    $error("FAIL %s match[dut%0d] observed=%0b expected=%0b", tag, i, act_m[i], e.m[i]);
                end
`ifdef MOORE_SEQ_CNT_EN
                checks++;
                assert (act_cnt[i] === e.cnt[i*8 +: 8]) else begin
                    errors++;
                    $error("FAIL %s match_cnt[dut%0d] observed=%0d expected=%0d", tag, i, act_cnt[i], e.cnt[i*8 +: 8]);
                end
`endif
            end
        end
    endtask

    task automatic step(input string tag, input bit e, input bit d, input bit c);
        en  = e;
        din = d;
        clr = c;
        model_step(e, d, c);
        sb.push_back(snapshot());
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        din   = 1'b0;
        clr   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(snapshot());
        check_out("reset");
        reset = 1'b0;

        // Stream 1,0,1,1,0,1,1: overlap matches twice, non-overlap once.
        step("s1", 1, 1, 0);
        step("s2", 1, 0, 0);
        step("s3", 1, 1, 0);
        step("s4", 1, 1, 0);
        step("s5", 1, 0, 0);
        step("s6", 1, 1, 0);
        step("s7", 1, 1, 0);

        // Reach state 3, then assert reset mid-cycle.
        step("clr1", 1, 0, 1);
        step("p1", 1, 1, 0);
        step("p2", 1, 0, 0);
        step("p3", 1, 1, 0);
        #3;
        reset = 1'b1;
        model_reset();
        sb.push_back(snapshot());
        #1;
        check_out("async_reset");
        @(negedge clk);
        reset = 1'b0;

        // en gating: prefix 1,0 held across a gap with din toggling.
        step("g1", 1, 1, 0);
        step("g2", 1, 0, 0);
        for (int i = 0; i < 5; i++) step("gap", 0, 1'(i % 2 == 0), 0);
        step("g3", 1, 1, 0);
        step("g4", 1, 1, 0);

        // Lock holds match through zeros until clr.
        step("l1", 1, 0, 0);
        step("l2", 1, 0, 0);
        step("l3", 1, 0, 0);
        step("lclr", 0, 0, 1);

        // Saturation of the 2-bit counter on a run of ones.
        for (int i = 0; i < 8; i++) step("sat", 1, 1, 0);

        // clr wins over a completing bit in the same cycle.
        step("pre", 1, 0, 1);
        step("c1", 1, 1, 0);
        step("clr_win", 1, 1, 1);
        step("post", 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
